// File: rtl/saber_pkg.sv
// Shared definitions for the Saber matrix-vector scheduler: FSM encoding,
// memory geometry and the matrix polynomial index helper.
package saber_pkg;

    localparam int WORDS          = 64;
    localparam int L_DEFAULT      = 3;
    localparam int RD_LAT_DEFAULT = 1;
    localparam int ADDR_W         = 9;
    localparam int IDX_W          = 4;
    localparam int RC_W           = 2;
    localparam int WORD_W         = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MUL,
        ST_NEXTK,
        ST_READ,
        ST_DRAIN,
        ST_FIN
    } state_t;

    // Row-major index of A[r][k], or of A[k][r] when the matrix is used transposed.
    function automatic logic [IDX_W-1:0] mat_index(input logic [RC_W-1:0] r,
                                                   input logic [RC_W-1:0] k,
                                                   input logic tr,
                                                   input int l);
        int major;
        int minor;
        major = tr ? int'(k) : int'(r);
        minor = tr ? int'(r) : int'(k);
        return IDX_W'(major * l + minor);
    endfunction

endpackage

// File: rtl/matvec_idx_gen.sv
// Row/product/word counters, matrix index selection and the delayed
// result-memory write port for the matrix-vector scheduler.
module matvec_idx_gen
    import saber_pkg::*;
#(
    parameter int L      = L_DEFAULT,
    parameter int RD_LAT = RD_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr,
    input  logic              k_inc,
    input  logic              row_next,
    input  logic              word_inc,
    input  logic              word_clr,
    input  logic              rd,
    input  logic              transpose,
    input  logic [ADDR_W-1:0] result_base,
    output logic [IDX_W-1:0]  a_index,
    output logic [RC_W-1:0]   pol_base_sel,
    output logic              first_k,
    output logic              last_k,
    output logic              last_r,
    output logic              last_word,
    output logic              drain_last,
    output logic [ADDR_W-1:0] write_address,
    output logic              wen
);

    logic [RC_W-1:0]   r_reg;
    logic [RC_W-1:0]   k_reg;
    logic [WORD_W-1:0] word_reg;
    logic              tr_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [ADDR_W-1:0] addr_now;
    logic [ADDR_W-1:0] addr_pipe_reg [RD_LAT];
    logic [RD_LAT-1:0] wen_pipe_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg    <= '0;
            k_reg    <= '0;
            word_reg <= '0;
            tr_reg   <= 1'b0;
            base_reg <= '0;
        end else begin
            if (load || clr) begin
                r_reg    <= '0;
                k_reg    <= '0;
                word_reg <= '0;
            end else begin
                if (row_next) begin
                    r_reg <= r_reg + RC_W'(1);
                    k_reg <= '0;
                end else if (k_inc) begin
                    k_reg <= k_reg + RC_W'(1);
                end
                // The word counter wraps to 0 after the last read word and then
                // doubles as the drain counter.
                if (word_clr) begin
                    word_reg <= '0;
                end else if (word_inc) begin
                    word_reg <= word_reg + WORD_W'(1);
                end
            end
            if (load) begin
                tr_reg   <= transpose;
                base_reg <= result_base;
            end
        end
    end

    assign a_index      = mat_index(r_reg, k_reg, tr_reg, L);
    assign pol_base_sel = k_reg;
    assign first_k      = (k_reg == '0);
    assign last_k       = (k_reg == RC_W'(L - 1));
    assign last_r       = (r_reg == RC_W'(L - 1));
    assign last_word    = (word_reg == WORD_W'(WORDS - 1));
    assign drain_last   = (word_reg == WORD_W'(RD_LAT - 1));
    assign addr_now     = base_reg + ADDR_W'(r_reg) * ADDR_W'(WORDS) + ADDR_W'(word_reg);

    // Match the multiplier's read latency so address and strobe meet the data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                addr_pipe_reg[i] <= '0;
            end
            wen_pipe_reg <= '0;
        end else begin
            addr_pipe_reg[0] <= addr_now;
            wen_pipe_reg[0]  <= rd;
            for (int i = 1; i < RD_LAT; i++) begin
                addr_pipe_reg[i] <= addr_pipe_reg[i-1];
                wen_pipe_reg[i]  <= wen_pipe_reg[i-1];
            end
        end
    end

    assign write_address = addr_pipe_reg[RD_LAT-1];
    assign wen           = wen_pipe_reg[RD_LAT-1];

endmodule

// File: rtl/matvec_mul_scheduler.sv
// Sequences the polynomial multiplier through an LxL matrix-vector product,
// one accumulated row at a time, and streams each row into polynomial memory.
module matvec_mul_scheduler
    import saber_pkg::*;
#(
    parameter int L      = L_DEFAULT,
    parameter int RD_LAT = RD_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              transpose,
    input  logic [ADDR_W-1:0] result_base,
    output logic              busy,
    output logic              done,
    output logic              rst_pol_mul,
    output logic              pol_acc_clear,
    output logic [IDX_W-1:0]  a_index,
    output logic [RC_W-1:0]   pol_base_sel,
    input  logic              pol_mul_done,
    output logic              result_pol_read,
    output logic [ADDR_W-1:0] write_address,
    output logic              PolMem_wen
);

    state_t state_reg;
    state_t state_next;

    logic load;
    logic clr;
    logic k_inc;
    logic row_next;
    logic word_inc;
    logic word_clr;
    logic first_k;
    logic last_k;
    logic last_r;
    logic last_word;
    logic drain_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_MUL;
            // pol_mul_done is only trusted while the multiplier is out of reset.
            ST_MUL:   if (pol_mul_done) state_next = ST_NEXTK;
            ST_NEXTK: state_next = last_k ? ST_READ : ST_LOAD;
            ST_READ:  if (last_word) state_next = ST_DRAIN;
            ST_DRAIN: if (drain_last) state_next = last_r ? ST_FIN : ST_LOAD;
            ST_FIN:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy            = (state_reg != ST_IDLE) && (state_reg != ST_FIN);
        done            = (state_reg == ST_FIN);
        rst_pol_mul     = (state_reg != ST_MUL);
        pol_acc_clear   = ((state_reg == ST_LOAD) || (state_reg == ST_MUL)) && first_k;
        result_pol_read = (state_reg == ST_READ);
        load            = (state_reg == ST_IDLE) && start;
        clr             = (state_reg == ST_FIN);
        k_inc           = (state_reg == ST_NEXTK) && !last_k;
        row_next        = (state_reg == ST_DRAIN) && drain_last && !last_r;
        word_inc        = (state_reg == ST_READ) || (state_reg == ST_DRAIN);
        word_clr        = (state_reg == ST_DRAIN) && drain_last;
    end

    matvec_idx_gen #(
        .L      (L),
        .RD_LAT (RD_LAT)
    ) u_idx_gen (
        .clk           (clk),
        .rst           (rst),
        .load          (load),
        .clr           (clr),
        .k_inc         (k_inc),
        .row_next      (row_next),
        .word_inc      (word_inc),
        .word_clr      (word_clr),
        .rd            (result_pol_read),
        .transpose     (transpose),
        .result_base   (result_base),
        .a_index       (a_index),
        .pol_base_sel  (pol_base_sel),
        .first_k       (first_k),
        .last_k        (last_k),
        .last_r        (last_r),
        .last_word     (last_word),
        .drain_last    (drain_last),
        .write_address (write_address),
        .wen           (PolMem_wen)
    );

endmodule

// File: tb/tb_matvec_mul_scheduler.sv
// Directed bench for matvec_mul_scheduler with a fixed-latency multiplier model.
module tb_matvec_mul_scheduler;

    localparam int T_MUL = 10;
    localparam int LIMIT = 2000;
    localparam logic [20:0] RST_VEC = 21'b0_0_1_0_0000_00_0_000000000_0;
    localparam logic [35:0] SEQ_N   = 36'h012345678;
    localparam logic [35:0] SEQ_T   = 36'h036147258;
    localparam logic [17:0] PSEL    = 18'b00_01_10_00_01_10_00_01_10;
    localparam logic [8:0]  CLRS    = 9'b100_100_100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       transpose = 1'b0;
    logic [8:0] result_base = '0;
    logic       busy, done, rst_pol_mul, pol_acc_clear, pol_mul_done;
    logic [3:0] a_index;
    logic [1:0] pol_base_sel;
    logic       result_pol_read, PolMem_wen;
    logic [8:0] write_address;

    int   checks = 0;
    int   failures = 0;
    int   mul_cnt;
    bit   fault = 1'b0;

    logic [8:0]  wr_q[$];
    logic [35:0] a_seq;
    logic [17:0] ps_seq;
    logic [8:0]  clr_seq;
    int          done_cnt;
    int          unstable;
    logic        prev_rpm;
    logic [3:0]  prev_a;
    logic        busy1;

    matvec_mul_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .transpose       (transpose),
        .result_base     (result_base),
        .busy            (busy),
        .done            (done),
        .rst_pol_mul     (rst_pol_mul),
        .pol_acc_clear   (pol_acc_clear),
        .a_index         (a_index),
        .pol_base_sel    (pol_base_sel),
        .pol_mul_done    (pol_mul_done),
        .result_pol_read (result_pol_read),
        .write_address   (write_address),
        .PolMem_wen      (PolMem_wen)
    );

    always #5 clk = ~clk;

    // Multiplier model: done after T_MUL cycles out of reset; the fault mode
    // also drives done high while held in reset.
    always_ff @(posedge clk) begin
        mul_cnt <= rst_pol_mul ? 0 : mul_cnt + 1;
    end
    assign pol_mul_done = (!rst_pol_mul && mul_cnt == T_MUL - 1) || (fault && rst_pol_mul);

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic clear_mon();
        wr_q.delete();
        a_seq = '0;
        ps_seq = '0;
        clr_seq = '0;
        done_cnt = 0;
        unstable = 0;
        prev_rpm = 1'b1;
        prev_a = '0;
    endtask

    // Called once per cycle at the falling edge.
    task automatic sample();
        if (PolMem_wen) wr_q.push_back(write_address);
        if (!rst_pol_mul && prev_rpm) begin
            a_seq   = {a_seq[31:0], a_index};
            ps_seq  = {ps_seq[15:0], pol_base_sel};
            clr_seq = {clr_seq[7:0], pol_acc_clear};
        end
        if (!rst_pol_mul && !prev_rpm && a_index != prev_a) unstable++;
        if (done) done_cnt++;
        prev_rpm = rst_pol_mul;
        prev_a = a_index;
    endtask

    task automatic run_cmd(input logic tr, input logic [8:0] base, input bit disturb, output int lat);
        bit sent;
        clear_mon();
        sent = 1'b0;
        @(negedge clk);
        start = 1'b1;
        transpose = tr;
        result_base = base;
        lat = 0;
        while (done_cnt == 0 && lat < LIMIT) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
            if (disturb && !sent && !rst_pol_mul && a_index == 4'd3) begin
                start = 1'b1;
                sent = 1'b1;
            end
            sample();
            if (lat == 1) busy1 = busy;
        end
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            sample();
        end
    endtask

    task automatic check_writes(input string tag, input logic [8:0] base);
        int errs;
        logic [8:0] e;
        errs = 0;
        check_val({tag, "_nwr"}, 64'(wr_q.size()), 64'd192);
        for (int i = 0; i < wr_q.size() && i < 192; i++) begin
            e = base + 9'(i);
            if (wr_q[i] !== e) errs++;
        end
        check_val({tag, "_addr_err"}, 64'(errs), 64'd0);
    endtask

    task automatic check_run(input string tag, input int lat, input logic [35:0] seq);
        check_val({tag, "_lat"}, 64'(lat), 64'd304);
        check_val({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check_val({tag, "_busy1"}, 64'(busy1), 64'd1);
        check_val({tag, "_busy_end"}, 64'(busy), 64'd0);
        check_val({tag, "_aseq"}, 64'(a_seq), 64'(seq));
        check_val({tag, "_psel"}, 64'(ps_seq), 64'(PSEL));
        check_val({tag, "_clr"}, 64'(clr_seq), 64'(CLRS));
        check_val({tag, "_stable"}, 64'(unstable), 64'd0);
    endtask

    function automatic logic [20:0] out_vec();
        return {busy, done, rst_pol_mul, pol_acc_clear, a_index, pol_base_sel,
                result_pol_read, write_address, PolMem_wen};
    endfunction

    initial begin
        int lat;
        int n;
        clear_mon();
        repeat (3) @(negedge clk);
        check_val("reset_outs", 64'(out_vec()), 64'(RST_VEC));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_val("idle_outs", 64'(out_vec()), 64'(RST_VEC));

        run_cmd(1'b0, 9'd0, 1'b0, lat);
        $display("txn plain:     lat=%0d writes=%0d done=%0d", lat, wr_q.size(), done_cnt);
        check_run("plain", lat, SEQ_N);
        check_writes("plain", 9'd0);

        run_cmd(1'b1, 9'd0, 1'b0, lat);
        $display("txn transpose: lat=%0d writes=%0d done=%0d", lat, wr_q.size(), done_cnt);
        check_run("tr", lat, SEQ_T);
        check_writes("tr", 9'd0);

        run_cmd(1'b0, 9'd448, 1'b0, lat);
        $display("txn wrap:      lat=%0d writes=%0d done=%0d", lat, wr_q.size(), done_cnt);
        check_val("wrap_done_cnt", 64'(done_cnt), 64'd1);
        check_writes("wrap", 9'd448);
        if (wr_q.size() == 192) begin
            check_val("wrap_first", 64'(wr_q[0]), 64'd448);
            check_val("wrap_w64", 64'(wr_q[64]), 64'd0);
            check_val("wrap_last", 64'(wr_q[191]), 64'd127);
        end

        run_cmd(1'b0, 9'd0, 1'b1, lat);
        $display("txn disturb:   lat=%0d writes=%0d done=%0d", lat, wr_q.size(), done_cnt);
        check_run("dist", lat, SEQ_N);
        check_writes("dist", 9'd0);

        // Abort during row 0 readout, word 20.
        clear_mon();
        @(negedge clk);
        start = 1'b1;
        transpose = 1'b0;
        result_base = 9'd0;
        n = 0;
        @(negedge clk);
        start = 1'b0;
        sample();
        while (!(wr_q.size() == 20 && result_pol_read) && n < LIMIT) begin
            @(negedge clk);
            sample();
            n++;
        end
        check_val("abort_reached", 64'(n < LIMIT), 64'd1);
        #2 rst = 1'b0;
        #1 check_val("abort_outs", 64'(out_vec()), 64'(RST_VEC));
        repeat (3) begin
            @(negedge clk);
            sample();
        end
        rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            sample();
        end
        $display("txn abort:     writes=%0d busy=%0d", wr_q.size(), busy);
        check_val("abort_nwr", 64'(wr_q.size()), 64'd20);
        check_val("abort_idle", 64'(out_vec()), 64'(RST_VEC));

        run_cmd(1'b0, 9'd0, 1'b0, lat);
        $display("txn rerun:     lat=%0d writes=%0d done=%0d", lat, wr_q.size(), done_cnt);
        check_run("rerun", lat, SEQ_N);
        check_writes("rerun", 9'd0);

        fault = 1'b1;
        run_cmd(1'b0, 9'd0, 1'b0, lat);
        fault = 1'b0;
        $display("txn fault:     lat=%0d writes=%0d done=%0d", lat, wr_q.size(), done_cnt);
        check_run("fault", lat, SEQ_N);
        check_writes("fault", 9'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matvec_mul_scheduler.md
Name: matvec_mul_scheduler

Overview:
- Sequences the 256-coefficient polynomial multiplier (start/clear/readout) through a full LxL matrix-vector product, as used in Saber key generation, encryption and decryption.
- For each output row r: accumulates sum over k of A[r][k]*s[k], or A[k][r]*s[k] when transposed.
- Writes each row as 64 packed 64-bit words into polynomial memory.
- Sits between the top-level instruction decoder and the multiplier, replacing hand-issued per-polynomial commands.

Parameters:
- L, 3, vector rank (legal 2..4); rows = L, products per row = L.
- WORDS, 64, 64-bit result words per polynomial (256 coeffs x 16 bit).
- RD_LAT, 1, cycles from result_pol_read to valid coeff4x data at the memory write port.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle command pulse; accepted only in IDLE.
- transpose  in  1  0: A[r][k]; 1: A[k][r]; latched on start.
- result_base  in  9  word address of row 0 result; latched on start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when the last result word has been written.
- rst_pol_mul  out  1  high holds the multiplier in reset; a falling edge starts one product.
- pol_acc_clear  out  1  high during the first product (k=0) of a row.
- a_index  out  4  matrix polynomial index: r*L+k, or k*L+r when transposed.
- pol_base_sel  out  2  s polynomial index k.
- pol_mul_done  in  1  level from the multiplier; valid only while rst_pol_mul is low.
- result_pol_read  out  1  high for WORDS cycles per row during readout.
- write_address  out  9  result_base + r*WORDS + word, modulo 512.
- PolMem_wen  out  1  write strobe, aligned with valid coeff4x data.

Behaviour:
- Reset values: busy=0, done=0, rst_pol_mul=1, pol_acc_clear=0, a_index=0, pol_base_sel=0, result_pol_read=0, write_address=0, PolMem_wen=0.
- Reset asserted mid-operation aborts immediately to IDLE. No partial-row cleanup; memory contents are undefined.
- States:
  - IDLE: rst_pol_mul=1. start -> LOAD. Latch transpose and result_base; r=0, k=0; busy=1.
  - LOAD (1 cycle): rst_pol_mul=1. Drive a_index and pol_base_sel for the current (r,k). pol_acc_clear=(k==0). -> MUL.
  - MUL: rst_pol_mul=0; indices and pol_acc_clear held stable. pol_mul_done=1 -> NEXTK.
  - NEXTK (1 cycle): rst_pol_mul=1. If k<L-1: k++, -> LOAD. Otherwise -> READ.
  - READ: result_pol_read=1 for exactly WORDS cycles; word counter runs 0..WORDS-1. The last cycle -> DRAIN.
  - DRAIN: RD_LAT cycles for the final delayed writes. Then: if r<L-1, r++, k=0, -> LOAD; otherwise -> FIN.
  - FIN (1 cycle): done=1, busy=0. -> IDLE.
- Write path:
  - PolMem_wen and write_address are result_pol_read and the word address delayed by RD_LAT registers.
  - Exactly WORDS writes per row, L*WORDS writes per command, at strictly increasing addresses (mod 512).
- pol_mul_done is ignored outside MUL. A stale high level in the first MUL cycle is not possible, because the multiplier clears it while rst_pol_mul=1. No timeout.
- start while busy: ignored, with no side effects. start in the same cycle as FIN: ignored; it must be reissued.
- Address arithmetic: 9-bit, wraps modulo 512. result_base + L*WORDS > 512 wraps silently.
- Per-row latency: L*(2 + T_mul) + WORDS + RD_LAT cycles.
- Total command latency: start-accept to done = L * per-row latency + 1 cycle.

Decomposition:
- Shared package saber_pkg: state encoding, WORDS, default L, address width (9), matrix index width (4).
- One natural sub-module, matvec_idx_gen: r/k/word counters plus the transpose index and address generation. The FSM stays in the top.

Test Plan:
- L=3, transpose=0, result_base=0, multiplier model with T_mul=10.
  - a_index sequence is 0,1,2,3,4,5,6,7,8.
  - pol_acc_clear is high only at k=0.
  - 192 writes at addresses 0..191.
  - done occurs 3*(3*12+64+1)+1 = 304 cycles after start.
- transpose=1, L=3: a_index sequence is 0,3,6,1,4,7,2,5,8; pol_base_sel cycles 0,1,2 for each row.
- result_base=448, L=3: writes 448..511, then 0..127 (wrap); done asserted once.
- start pulsed during MUL of row 1: ignored. Outputs are identical to an undisturbed run, with a single done pulse.
- rst asserted low during READ of row 0, word 20:
  - All outputs reach reset values asynchronously; no wen afterwards.
  - A subsequent start runs a full, correct 192-write sequence.
- pol_mul_done held high while rst_pol_mul=1 (faulty model) during LOAD/NEXTK: no state advance. MUL waits for done with rst_pol_mul low.
